// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_sched_if
//  Purpose  : Bundle of the two result-producer handshakes, the hold control
//             and the register-file write port used by regfile_wb_sched.
//  Ports    : a_valid/a_reg/a_data/a_ready   requester A (ALU path)
//             b_valid/b_reg/b_data/b_ready   requester B (memory/load path)
//             hold                           freeze grants
//             rf_write/rf_dst_reg/rf_dst_data register-file write port
//             pending                        per-register outstanding-write map
//             busy                           either buffer holds an entry
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_sched_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic                 a_valid;
  logic [AW-1:0]        a_reg;
  logic [DW-1:0]        a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [AW-1:0]        b_reg;
  logic [DW-1:0]        b_data;
  logic                 b_ready;
  logic                 hold;
  logic                 rf_write;
  logic [AW-1:0]        rf_dst_reg;
  logic [DW-1:0]        rf_dst_data;
  logic [(1<<AW)-1:0]   pending;
  logic                 busy;

  // Scheduler side
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, hold,
    output a_ready, b_ready, rf_write, rf_dst_reg, rf_dst_data, pending, busy
  );

  // Producer / register-file side
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, hold,
    input  a_ready, b_ready, rf_write, rf_dst_reg, rf_dst_data, pending, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_sched
//  Purpose  : Write-back scheduler for the register file's single write port.
//             Two one-entry buffers (A = ALU, B = load) are drained oldest
//             first, one write per cycle. Writes to r0 drain silently.
//  Ports    : clk   clock, rising-edge
//             rst   asynchronous active-high reset
//             bus   regfile_wb_sched_if.slave (handshakes, hold, write port,
//                   pending map, busy)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_wb_sched_if.slave  bus
);
  localparam int c_NREG = 1 << AW;

  logic          r_av, r_bv;
  logic [AW-1:0] r_areg, r_breg;
  logic [DW-1:0] r_adata, r_bdata;
  logic          r_a_older;

  logic          w_grant_a, w_grant_b;
  logic          w_load_a, w_load_b;
  logic          w_a_surv, w_b_surv;
  logic          w_a_older_n;
  logic [AW-1:0] w_sel_reg;
  logic [DW-1:0] w_sel_data;
  logic [c_NREG-1:0] w_pending;

  // Oldest-first grant; at most one side can win since the age flag breaks ties.
  assign w_grant_a = !bus.hold && r_av && (!r_bv || r_a_older);
  assign w_grant_b = !bus.hold && r_bv && (!r_av || !r_a_older);

  // Ready depends only on buffer state, so a draining buffer refills in place.
  assign bus.a_ready = !r_av || w_grant_a;
  assign bus.b_ready = !r_bv || w_grant_b;
  assign w_load_a    = bus.a_valid && bus.a_ready;
  assign w_load_b    = bus.b_valid && bus.b_ready;

  // An entry that stays put across the edge is older than anything loaded now.
  assign w_a_surv = r_av && !w_grant_a;
  assign w_b_surv = r_bv && !w_grant_b;

  always_comb begin
    w_a_older_n = r_a_older;
    if (w_a_surv && !w_b_surv)
      w_a_older_n = 1'b1;
    else if (w_b_surv && !w_a_surv)
      w_a_older_n = 1'b0;
    else if (!w_a_surv && !w_b_surv)
      w_a_older_n = 1'b1;   // fresh pair: A counts as older so B lands last
  end

  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    if (w_grant_a) begin
      w_sel_reg  = r_areg;
      w_sel_data = r_adata;
    end else if (w_grant_b) begin
      w_sel_reg  = r_breg;
      w_sel_data = r_bdata;
    end
  end

  // r0 entries still drain, they just never strobe the write enable.
  assign bus.rf_write    = (w_grant_a || w_grant_b) && (w_sel_reg != '0);
  assign bus.rf_dst_reg  = w_sel_reg;
  assign bus.rf_dst_data = w_sel_data;

  always_comb begin
    w_pending = '0;
    if (r_av) w_pending[r_areg] = 1'b1;
    if (r_bv) w_pending[r_breg] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign bus.pending = w_pending;
  assign bus.busy    = r_av || r_bv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_av      <= 1'b0;
      r_bv      <= 1'b0;
      r_areg    <= '0;
      r_breg    <= '0;
      r_adata   <= '0;
      r_bdata   <= '0;
      r_a_older <= 1'b1;
    end else begin
      if (w_load_a) begin
        r_av    <= 1'b1;
        r_areg  <= bus.a_reg;
        r_adata <= bus.a_data;
      end else if (w_grant_a) begin
        r_av    <= 1'b0;
      end
      if (w_load_b) begin
        r_bv    <= 1'b1;
        r_breg  <= bus.b_reg;
        r_bdata <= bus.b_data;
      end else if (w_grant_b) begin
        r_bv    <= 1'b0;
      end
      r_a_older <= w_a_older_n;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_sched
//  Purpose  : Self-checking bench for regfile_wb_sched. Stimulus pushes the
//             expected register-file writes into a queue; a negedge monitor
//             pops and compares whenever rf_write is asserted.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_sched;
  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  exp_q[$];
  logic [15:0] rf_m [16];

  regfile_wb_sched_if #(.DW(16), .AW(4)) bus ();

  regfile_wb_sched #(.DW(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (bus.rf_write === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got r%0d=%0h expected none", bus.rf_dst_reg, bus.rf_dst_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rf_dst_reg !== e.r || bus.rf_dst_data !== e.d) begin
          n_fail++;
          $display("FAIL write_order: got r%0d=%0h expected r%0d=%0h",
                   bus.rf_dst_reg, bus.rf_dst_data, e.r, e.d);
        end
      end
      rf_m[bus.rf_dst_reg] = bus.rf_dst_data;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    rst = 1'b1;
    bus.a_valid = 0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_reg = '0; bus.b_data = '0;
    bus.hold = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset / idle
    chk("idle_a_ready", bus.a_ready, 1);
    chk("idle_b_ready", bus.b_ready, 1);
    chk("idle_rf_write", bus.rf_write, 0);
    chk("idle_pending", bus.pending, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_dst_reg", bus.rf_dst_reg, 0);

    // Single A write
    bus.a_valid = 1; bus.a_reg = 4'd5; bus.a_data = 16'hBEEF;
    push(4'd5, 16'hBEEF);
    tick();
    bus.a_valid = 0;
    chk("single_rf_write", bus.rf_write, 1);
    chk("single_pending", bus.pending, 16'h0020);
    chk("single_busy", bus.busy, 1);
    tick();
    chk("single_pending_clr", bus.pending, 0);
    chk("single_busy_clr", bus.busy, 0);

    // Simultaneous A and B to r3: A first, B (load) wins
    bus.a_valid = 1; bus.a_reg = 4'd3; bus.a_data = 16'h1111;
    bus.b_valid = 1; bus.b_reg = 4'd3; bus.b_data = 16'h2222;
    push(4'd3, 16'h1111);
    push(4'd3, 16'h2222);
    tick();
    bus.a_valid = 0; bus.b_valid = 0;
    chk("sim_a_ready", bus.a_ready, 1);
    chk("sim_b_ready", bus.b_ready, 0);
    chk("sim_dst_data1", bus.rf_dst_data, 16'h1111);
    tick();
    chk("sim_dst_data2", bus.rf_dst_data, 16'h2222);
    tick();
    chk("sim_r3_final", rf_m[3], 16'h2222);

    // Both streaming: grants alternate A,B,A,B...
    for (int i = 0; i < 4; i++) begin
      push(4'(1 + i), 16'hA001 + 16'(i));
      push(4'(8 + i), 16'hB008 + 16'(i));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int guard;
          bus.a_valid = 1; bus.a_reg = 4'(1 + i); bus.a_data = 16'hA001 + 16'(i);
          guard = 0;
          @(negedge clk);
          while (!bus.a_ready && guard < 20) begin @(negedge clk); guard++; end
          if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL stream_a_timeout: got a_ready=0 expected 1");
          end
          tick();
        end
        bus.a_valid = 0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          int guard;
          bus.b_valid = 1; bus.b_reg = 4'(8 + i); bus.b_data = 16'hB008 + 16'(i);
          guard = 0;
          @(negedge clk);
          while (!bus.b_ready && guard < 20) begin @(negedge clk); guard++; end
          if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL stream_b_timeout: got b_ready=0 expected 1");
          end
          tick();
        end
        bus.b_valid = 0;
      end
    join
    tick(); tick();
    chk("stream_r4", rf_m[4], 16'hA004);
    chk("stream_r11", rf_m[11], 16'hB00B);

    // Write to r0: drains without a write strobe
    bus.a_valid = 1; bus.a_reg = 4'd0; bus.a_data = 16'hFFFF;
    tick();
    bus.a_valid = 0;
    chk("r0_rf_write", bus.rf_write, 0);
    chk("r0_pending", bus.pending, 0);
    chk("r0_busy", bus.busy, 1);
    chk("r0_a_ready", bus.a_ready, 1);
    tick();
    chk("r0_busy_clr", bus.busy, 0);

    // Hold with both buffers full; B loaded first so B is older
    bus.hold = 1;
    bus.b_valid = 1; bus.b_reg = 4'd7; bus.b_data = 16'h7777;
    tick();
    bus.b_valid = 0;
    bus.a_valid = 1; bus.a_reg = 4'd6; bus.a_data = 16'h6666;
    tick();
    bus.a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_rf_write", bus.rf_write, 0);
      chk("hold_a_ready", bus.a_ready, 0);
      chk("hold_b_ready", bus.b_ready, 0);
      chk("hold_pending", bus.pending, 16'h00C0);
      tick();
    end
    push(4'd7, 16'h7777);
    push(4'd6, 16'h6666);
    bus.hold = 0;
    #1;
    chk("release_first_reg", bus.rf_dst_reg, 7);
    tick();
    chk("release_second_reg", bus.rf_dst_reg, 6);
    tick();

    // Asynchronous reset mid-cycle with both buffers full
    bus.hold = 1;
    bus.a_valid = 1; bus.a_reg = 4'd2; bus.a_data = 16'h2020;
    bus.b_valid = 1; bus.b_reg = 4'd4; bus.b_data = 16'h4040;
    tick();
    bus.a_valid = 0; bus.b_valid = 0;
    chk("prerst_pending", bus.pending, 16'h0014);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_a_ready", bus.a_ready, 1);
    chk("arst_b_ready", bus.b_ready, 1);
    chk("arst_pending", bus.pending, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rf_write", bus.rf_write, 0);
    chk("arst_dst_data", bus.rf_dst_data, 0);
    bus.hold = 0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("postrst_busy", bus.busy, 0);

    // Drain and final scoreboard check
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    chk("final_busy", bus.busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
